panel_sequencer: RTL and testbench
==================================

# panel_sequencer

Front-panel command sequencer between the `keyboard` strobes and `cpu_control`. It assembles hex keypad digits into an entry register and tracks the panel's current memory address. It turns load / store-increment / decrement / register-load keys into a serialized stream of bus commands over a valid/ready handshake. It also reads back memory data for the display, and runs only while the CPU is stopped.

## Interface
- `TIMEOUT_W`, default 8: width of the read-data timeout counter; timeout after 2^TIMEOUT_W−1 cycles.
- `clk`  in  1  system clock (CLK25MHZ domain)
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `b_hex`  in  16  one-hot hex key strobes; bit n = digit n, single-cycle pulses
- `b_load`, `b_storeinc`, `b_dec`, `b_toA`, `b_toX`, `b_toY`, `b_toSP`, `b_toPC`  in  1 each  single-cycle key strobes
- `stopped`  in  1  CPU halted; commands accepted only when high
- `cmd_valid`  out  1  command request
- `cmd_op`  out  3  0 READ, 1 WRITE, 2 SET_A, 3 SET_X, 4 SET_Y, 5 SET_SP, 6 SET_PC
- `cmd_addr`  out  16  memory address (READ/WRITE) or new PC (SET_PC)
- `cmd_data`  out  8  write / register data
- `cmd_ready`  in  1  command accepted when `cmd_valid & cmd_ready`
- `rd_data`  in  8  read return data
- `rd_valid`  in  1  single-cycle read return strobe
- `entry`  out  16  digit entry register
- `addr`  out  16  current panel address
- `data_disp`  out  8  last data read at `addr`
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  single-cycle pulse: rejected key or read timeout

## Operation
- States: IDLE, ISSUE, WAIT_RD, NEXT_RD.
- Reset: state IDLE. All outputs 0: `cmd_valid`, `cmd_op`, `cmd_addr`, `cmd_data`, `entry`, `addr`, `data_disp`, `busy`, `err`. Timeout counter 0.
- Keys are decoded only in IDLE with `stopped`=1. Otherwise any strobe is dropped and `err` pulses.
- Simultaneous strobes in one cycle: `b_hex` non-one-hot, or hex together with a command key, or more than one command key. The whole event is dropped and `err` pulses.
- Hex digit n: `entry <= {entry[11:0], n}`. No command is issued and the state stays IDLE.
- LOAD: `addr <= entry`, `entry <= 0`, issue READ at `entry`.
- STOREINC: issue WRITE, addr=`addr`, data=`entry[7:0]`. On accept, `addr <= addr+1`, `entry <= 0`, then state NEXT_RD, which issues READ at the new `addr`.
- DEC: `addr <= addr−1`, issue READ at new address. `entry` is unchanged.
- toA/X/Y/SP: issue SET_x with `cmd_data = entry[7:0]`, `entry <= 0`.
- toPC: issue SET_PC with `cmd_addr = entry`, `entry <= 0`.
- ISSUE: `cmd_valid`=1 with op/addr/data stable until accepted. A command is never withdrawn, even if `stopped` falls.
  - On accept: READ → WAIT_RD; WRITE → NEXT_RD; SET_x → IDLE.
- WAIT_RD: on `rd_valid`, `data_disp <= rd_data` and go to IDLE. The timeout counter increments each cycle. At 2^TIMEOUT_W−1 the block pulses `err`, goes to IDLE, and leaves `data_disp` unchanged.
- `rd_valid` outside WAIT_RD is ignored.
- Address arithmetic is 16-bit modulo: FFFF+1 = 0000, 0000−1 = FFFF.
- Asynchronous reset mid-operation returns the block to the reset values immediately; the pending command is lost.

## Timing
- Key strobe at edge n → `cmd_valid` high after edge n+1. `addr`/`entry` updates are visible after edge n+1.
- Accept at edge k (`cmd_valid & cmd_ready` sampled) → `cmd_valid` low after k+1, except after WRITE.
  - After WRITE, NEXT_RD re-asserts `cmd_valid` with READ after edge k+2, and the incremented `addr` is visible after k+1.
- Minimum `cmd_valid` gap between the WRITE and the following READ: 1 cycle.
- `rd_valid` at edge r → `data_disp` updated and `busy` low after r+1.
- `cmd_ready` held high: a READ completes in 2 cycles plus the return latency.
- `err` is exactly one cycle wide and is registered, one cycle after the offending strobe or timeout.

## Test plan
- Reset, `stopped`=1: keys 1,2,3,4,LOAD → `entry`=1234 then 0. One command READ@1234 is issued. `rd_data`=A9 → `data_disp`=A9 and `addr`=1234.
- `addr`=FFFF, entry 5A, STOREINC with `cmd_ready` delayed 3 cycles → `cmd_valid` holds WRITE@FFFF data 5A for 4 cycles. Then `addr`=0000 and READ@0000 is issued.
- `addr`=0000, DEC → READ@FFFF is issued and `addr`=FFFF. No `rd_valid` → `err` pulses after 255 cycles, state returns to IDLE, and `data_disp` is unchanged.
- `stopped`=0, key 7 → `entry` unchanged, no `cmd_valid`, one `err` pulse. Key 7 pressed while in WAIT_RD → same response.
- Entry 01FC, toPC → SET_PC with `cmd_addr`=01FC. Entry 80, toX → SET_X with `cmd_data`=80. `b_toA` and `b_toY` in the same cycle → no command and `err`.
- Deassert `rst_n` while in WAIT_RD → all outputs 0 immediately. Subsequent keys operate normally.

Source files
------------

// File: rtl/panel_sequencer.sv
// panel_sequencer: front-panel keypad sequencer that turns key strobes into
// serialized bus commands over valid/ready and reads back memory for display.
module panel_sequencer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] b_hex,
    input  logic        b_load,
    input  logic        b_storeinc,
    input  logic        b_dec,
    input  logic        b_toA,
    input  logic        b_toX,
    input  logic        b_toY,
    input  logic        b_toSP,
    input  logic        b_toPC,
    input  logic        stopped,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_data,
    input  logic        cmd_ready,
    input  logic [7:0]  rd_data,
    input  logic        rd_valid,
    output logic [15:0] entry,
    output logic [15:0] addr,
    output logic [7:0]  data_disp,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, NEXT_RD} state_t;
    typedef enum logic [2:0] {OP_READ, OP_WRITE, OP_SET_A, OP_SET_X, OP_SET_Y, OP_SET_SP, OP_SET_PC} op_t;
    state_t               state;
    op_t                  key_op;
    logic [TIMEOUT_W-1:0] tmo, tmo_inc;
    logic [7:0]           cmds;
    logic [3:0]           hex_n;
    logic [15:0]          addr_dec;
    logic                 any_key, multi, bad_key;
    always_comb begin
        cmds     = {b_load, b_storeinc, b_dec, b_toA, b_toX, b_toY, b_toSP, b_toPC};
        hex_n    = '0;
        for (int i = 0; i < 16; i++) hex_n = b_hex[i] ? 4'(i) : hex_n;
        any_key  = (|b_hex) || (|cmds);
        multi    = ($countones(b_hex) > 1) || ($countones(cmds) > 1) || ((|b_hex) && (|cmds));
        bad_key  = any_key && (state != IDLE || !stopped || multi);
        key_op   = b_storeinc ? OP_WRITE : b_toA ? OP_SET_A : b_toX ? OP_SET_X : b_toY ? OP_SET_Y :
                   b_toSP ? OP_SET_SP : b_toPC ? OP_SET_PC : OP_READ;
        addr_dec = addr - 16'd1;
        tmo_inc  = tmo + TIMEOUT_W'(1);
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            entry     <= '0;
            addr      <= '0;
            data_disp <= '0;
            err       <= 1'b0;
            tmo       <= '0;
        end else begin
            err <= bad_key;
            case (state)
                IDLE: begin
                    if (any_key && !bad_key) begin
                        if (|b_hex) begin
                            entry <= {entry[11:0], hex_n};
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_op    <= key_op;
                            cmd_data  <= entry[7:0];
                            cmd_addr  <= b_dec ? addr_dec : b_storeinc ? addr : entry;
                            addr      <= b_dec ? addr_dec : b_load ? entry : addr;
                            entry     <= (b_dec || b_storeinc) ? entry : '0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        tmo       <= '0;
                        if (cmd_op == OP_READ) begin
                            state <= WAIT_RD;
                        end else if (cmd_op == OP_WRITE) begin
                            addr  <= addr + 16'd1;
                            entry <= '0;
                            state <= NEXT_RD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_RD: begin
                    if (rd_valid) begin
                        data_disp <= rd_data;
                        tmo       <= '0;
                        state     <= IDLE;
                    end else if (&tmo_inc) begin
                        err   <= 1'b1;
                        tmo   <= '0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo_inc;
                    end
                end
                NEXT_RD: begin
                    // addr already holds the post-write increment here
                    cmd_valid <= 1'b1;
                    cmd_op    <= OP_READ;
                    cmd_addr  <= addr;
                    state     <= ISSUE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_panel_sequencer.sv
// tb_panel_sequencer: scoreboard bench for panel_sequencer; expected commands
// are queued as keys are pressed and compared when the handshake completes.
module tb_panel_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, stopped = 1'b0, cmd_ready = 1'b0, rd_valid = 1'b0;
    logic [15:0] b_hex = '0;
    logic [7:0]  keys = '0, rd_data = '0;
    logic        cmd_valid, busy, err;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr, entry, addr;
    logic [7:0]  cmd_data, data_disp;
    localparam logic [7:0] K_LOAD = 8'h80, K_SINC = 8'h40, K_DEC = 8'h20, K_A = 8'h10,
                           K_X = 8'h08, K_Y = 8'h04, K_PC = 8'h01;
    typedef struct {logic [2:0] op; logic [15:0] a; logic [7:0] d; bit ca; bit cd;} exp_t;
    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;

    panel_sequencer #(.TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .b_hex(b_hex),
        .b_load(keys[7]), .b_storeinc(keys[6]), .b_dec(keys[5]), .b_toA(keys[4]),
        .b_toX(keys[3]), .b_toY(keys[2]), .b_toSP(keys[1]), .b_toPC(keys[0]),
        .stopped(stopped), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .entry(entry), .addr(addr), .data_disp(data_disp), .busy(busy), .err(err)
    );

    always #20 clk = ~clk;

    // Scoreboard: one pop per accepted command
    always begin
        @(negedge clk);
        #1;
        if (rst_n && cmd_valid && cmd_ready) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_cmd: got op %0d addr %h data %h, want none", cmd_op, cmd_addr, cmd_data);
            end else begin
                e = exp_q.pop_front();
                if (cmd_op !== e.op || (e.ca && cmd_addr !== e.a) || (e.cd && cmd_data !== e.d)) begin
                    miscompares++;
                    $display("FAIL cmd: got op %0d addr %h data %h, want op %0d addr %h data %h",
                             cmd_op, cmd_addr, cmd_data, e.op, e.a, e.d);
                end
            end
        end
    end

    task automatic press(input logic [15:0] h, input logic [7:0] k);
        @(negedge clk);
        b_hex = h;
        keys  = k;
        @(negedge clk);
        b_hex = '0;
        keys  = '0;
    endtask

    task automatic digits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) press(16'h0001 << v[i*4 +: 4], '0);
    endtask

    task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [7:0] d, input bit ca, input bit cd);
        exp_t e;
        e.op = op; e.a = a; e.d = d; e.ca = ca; e.cd = cd;
        exp_q.push_back(e);
    endtask

    task automatic rd_return(input logic [7:0] d);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = d;
        @(negedge clk);
        rd_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_data, entry, addr, data_disp, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid %b op %0d caddr %h cdata %h entry %h addr %h disp %h busy %b err %b, want all 0",
                     cmd_valid, cmd_op, cmd_addr, cmd_data, entry, addr, data_disp, busy, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        stopped   = 1'b1;
        cmd_ready = 1'b1;
        digits(16'h1234, 4);
        vectors++;
        if ({entry, cmd_valid, busy} !== {16'h1234, 2'b00}) begin
            miscompares++;
            $display("FAIL load_entry: got entry %h valid %b busy %b, want 1234 0 0", entry, cmd_valid, busy);
        end
        push(3'd0, 16'h1234, 8'h00, 1'b1, 1'b0);
        press('0, K_LOAD);
        vectors++;
        if ({entry, addr, cmd_valid, cmd_op, busy} !== {16'h0000, 16'h1234, 1'b1, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL load_issue: got entry %h addr %h valid %b op %0d busy %b, want 0000 1234 1 0 1",
                     entry, addr, cmd_valid, cmd_op, busy);
        end
        @(negedge clk);
        vectors++;
        if (cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_accept: got valid %b want 0", cmd_valid);
        end
        repeat (2) @(negedge clk);
        rd_return(8'hA9);
        vectors++;
        if ({data_disp, addr, busy} !== {8'hA9, 16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL load_readback: got disp %h addr %h busy %b, want a9 1234 0", data_disp, addr, busy);
        end
    endtask

    task automatic test_storeinc_wrap;
        int hold;
        digits(16'hFFFF, 4);
        push(3'd0, 16'hFFFF, 8'h00, 1'b1, 1'b0);
        press('0, K_LOAD);
        rd_return(8'h11);
        digits(16'h005A, 2);
        cmd_ready = 1'b0;
        push(3'd1, 16'hFFFF, 8'h5A, 1'b1, 1'b1);
        push(3'd0, 16'h0000, 8'h00, 1'b1, 1'b0);
        press('0, K_SINC);
        hold = 0;
        repeat (3) begin
            if (cmd_valid && cmd_op == 3'd1 && cmd_addr == 16'hFFFF && cmd_data == 8'h5A) hold++;
            @(negedge clk);
        end
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_op == 3'd1 && cmd_addr == 16'hFFFF && cmd_data == 8'h5A) hold++;
        @(negedge clk);
        vectors++;
        if (hold !== 4) begin
            miscompares++;
            $display("FAIL write_hold: got %0d cycles want 4", hold);
        end
        vectors++;
        if ({cmd_valid, addr, entry, busy} !== {1'b0, 16'h0000, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL write_accept: got valid %b addr %h entry %h busy %b, want 0 0000 0000 1",
                     cmd_valid, addr, entry, busy);
        end
        @(negedge clk);
        vectors++;
        if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 3'd0, 16'h0000}) begin
            miscompares++;
            $display("FAIL next_read: got valid %b op %0d addr %h, want 1 0 0000", cmd_valid, cmd_op, cmd_addr);
        end
        rd_return(8'h3C);
        vectors++;
        if ({data_disp, busy} !== {8'h3C, 1'b0}) begin
            miscompares++;
            $display("FAIL next_read_data: got disp %h busy %b, want 3c 0", data_disp, busy);
        end
    endtask

    task automatic test_dec_timeout;
        int n;
        digits(16'h0007, 1);
        push(3'd0, 16'hFFFF, 8'h00, 1'b1, 1'b0);
        press('0, K_DEC);
        vectors++;
        if ({addr, entry, cmd_valid, cmd_addr} !== {16'hFFFF, 16'h0007, 1'b1, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL dec_issue: got addr %h entry %h valid %b caddr %h, want ffff 0007 1 ffff",
                     addr, entry, cmd_valid, cmd_addr);
        end
        @(negedge clk);
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({n, busy, data_disp} !== {32'd255, 1'b0, 8'h3C}) begin
            miscompares++;
            $display("FAIL timeout: got %0d cycles busy %b disp %h, want 255 0 3c", n, busy, data_disp);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got err %b want 0", err);
        end
    endtask

    task automatic test_not_stopped;
        stopped = 1'b0;
        press(16'h0080, '0);
        vectors++;
        if ({entry, cmd_valid, err} !== {16'h0007, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL not_stopped: got entry %h valid %b err %b, want 0007 0 1", entry, cmd_valid, err);
        end
        @(negedge clk);
        vectors++;
        if ({err, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL not_stopped_pulse: got err %b busy %b, want 0 0", err, busy);
        end
        stopped = 1'b1;
        push(3'd0, 16'h0007, 8'h00, 1'b1, 1'b0);
        press('0, K_LOAD);
        @(negedge clk);
        press(16'h0080, '0);
        vectors++;
        if ({err, entry, busy} !== {1'b1, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL key_in_wait: got err %b entry %h busy %b, want 1 0000 1", err, entry, busy);
        end
        rd_return(8'h5E);
        vectors++;
        if ({data_disp, addr} !== {8'h5E, 16'h0007}) begin
            miscompares++;
            $display("FAIL key_in_wait_data: got disp %h addr %h, want 5e 0007", data_disp, addr);
        end
    endtask

    task automatic test_set_regs;
        digits(16'h01FC, 4);
        push(3'd6, 16'h01FC, 8'h00, 1'b1, 1'b0);
        press('0, K_PC);
        vectors++;
        if ({cmd_valid, cmd_op, entry} !== {1'b1, 3'd6, 16'h0000}) begin
            miscompares++;
            $display("FAIL set_pc: got valid %b op %0d entry %h, want 1 6 0000", cmd_valid, cmd_op, entry);
        end
        @(negedge clk);
        digits(16'h0080, 2);
        push(3'd3, 16'h0000, 8'h80, 1'b0, 1'b1);
        press('0, K_X);
        @(negedge clk);
        vectors++;
        if ({busy, cmd_valid, entry} !== {2'b00, 16'h0000}) begin
            miscompares++;
            $display("FAIL set_x_done: got busy %b valid %b entry %h, want 0 0 0000", busy, cmd_valid, entry);
        end
        press('0, K_A | K_Y);
        vectors++;
        if ({cmd_valid, err, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL multi_cmd: got valid %b err %b busy %b, want 0 1 0", cmd_valid, err, busy);
        end
        digits(16'h0005, 1);
        press(16'h0003, '0);
        vectors++;
        if ({err, entry} !== {1'b1, 16'h0005}) begin
            miscompares++;
            $display("FAIL multi_hex: got err %b entry %h, want 1 0005", err, entry);
        end
        press(16'h0002, K_LOAD);
        vectors++;
        if ({err, entry, addr, cmd_valid} !== {1'b1, 16'h0005, 16'h0007, 1'b0}) begin
            miscompares++;
            $display("FAIL hex_plus_cmd: got err %b entry %h addr %h valid %b, want 1 0005 0007 0",
                     err, entry, addr, cmd_valid);
        end
    endtask

    task automatic test_async_reset;
        push(3'd0, 16'h0005, 8'h00, 1'b1, 1'b0);
        press('0, K_LOAD);
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        vectors++;
        if ({cmd_valid, cmd_op, cmd_addr, cmd_data, entry, addr, data_disp, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got valid %b op %0d caddr %h entry %h addr %h disp %h busy %b, want all 0",
                     cmd_valid, cmd_op, cmd_addr, entry, addr, data_disp, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_return(8'h11);
        vectors++;
        if ({data_disp, busy} !== 9'h000) begin
            miscompares++;
            $display("FAIL rd_idle_ignored: got disp %h busy %b, want 00 0", data_disp, busy);
        end
        digits(16'h0004, 1);
        push(3'd0, 16'h0004, 8'h00, 1'b1, 1'b0);
        press('0, K_LOAD);
        rd_return(8'h77);
        vectors++;
        if ({data_disp, addr, busy} !== {8'h77, 16'h0004, 1'b0}) begin
            miscompares++;
            $display("FAIL after_reset: got disp %h addr %h busy %b, want 77 0004 0", data_disp, addr, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_storeinc_wrap();
        test_dec_timeout();
        test_not_stopped();
        test_set_regs();
        test_async_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
